// File: rtl/div_pkg.sv
// div_pkg
//   Shared definitions for the sequential divider: operand width, iteration
//   count, divide-by-zero quotient and the FSM state encoding.
package div_pkg;

   localparam int          DIV_WIDTH    = 32;
   localparam int          DIV_ITERS    = 32;
   localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/sub32.sv
// sub32
//   Combinational 32-bit ripple-borrow subtractor: diff = a - b - b_in.
//   Ports:
//     a, b   : 32-bit minuend / subtrahend
//     b_in   : borrow into bit 0
//     diff   : 32-bit difference
//     b_out  : borrow out of bit 31 (set when a < b + b_in)
module sub32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        b_in,
   output logic [31:0] diff,
   output logic        b_out
);

   logic [32:0] bw;

   assign bw[0] = b_in;

   for (genvar i = 0; i < 32; i++) begin : g_bit
      assign diff[i]  = a[i] ^ b[i] ^ bw[i];
      // Borrow when a<b at this bit, or bits equal and a borrow ripples in.
      assign bw[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
   end

   assign b_out = bw[32];

endmodule

// File: rtl/seq_divider32.sv
// seq_divider32
//   Multi-cycle unsigned restoring divider, one trial subtraction per clock.
//   A start accepted in IDLE or DONE latches the operands; 32 RUN cycles
//   later quotient/remainder are loaded and done pulses for one cycle.
//   A zero divisor skips RUN and reports quotient=all-ones, remainder=dividend.
//   Ports:
//     clk, rst              : clock, asynchronous active-high reset
//     start                 : request, honoured only in IDLE or DONE
//     dividend, divisor     : unsigned operands, sampled on an accepted start
//     busy                  : high while iterating (RUN)
//     done                  : one-cycle strobe in DONE
//     quotient, remainder   : results, held until the next accepted start
//     div_by_zero           : set with done when divisor was zero
module seq_divider32
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam logic [5:0] LAST_CNT = 6'(DIV_ITERS - 1);

   state_t      state;
   logic [5:0]  cnt;

   logic [32:0] rem;
   logic [31:0] quo;
   logic [31:0] dvs;

   logic [32:0] sr;
   logic [31:0] diff;
   logic        b_out;
   logic        ok;
   logic [32:0] rem_nxt;
   logic [31:0] quo_nxt;
   logic        accept;

   // rem never exceeds dvs after a restore step, so its top bit is only
   // carried for the shifted form and is not read back directly.
   logic        unused_rem_msb;
   assign unused_rem_msb = rem[32];

   assign accept = start && ((state == S_IDLE) || (state == S_DONE));

   assign sr = {rem[31:0], quo[31]};

   sub32 u_sub (
      .a     (sr[31:0]),
      .b     (dvs),
      .b_in  (1'b0),
      .diff  (diff),
      .b_out (b_out)
   );

   // A set sr[32] means the shifted remainder already exceeds any 32-bit
   // divisor, so the subtraction is valid even though the 32-bit chain borrows.
   assign ok      = sr[32] | ~b_out;
   assign rem_nxt = ok ? {1'b0, diff} : sr;
   assign quo_nxt = {quo[30:0], ok};

   // Working datapath registers: no reset needed, always loaded on accept.
   always_ff @(posedge clk) begin
      if (accept) begin
         dvs <= divisor;
         quo <= dividend;
         rem <= '0;
      end else if (state == S_RUN) begin
         rem <= rem_nxt;
         quo <= quo_nxt;
      end
   end

   // Control FSM with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               done <= 1'b0;
               if (start) begin
                  cnt <= '0;
                  if (divisor == '0) begin
                     state       <= S_DONE;
                     busy        <= 1'b0;
                     done        <= 1'b1;
                     quotient    <= DIV_ZERO_QUO;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end else begin
                     state <= S_RUN;
                     busy  <= 1'b1;
                  end
               end else begin
                  state <= S_IDLE;
               end
            end
            S_RUN: begin
               cnt <= cnt + 6'd1;
               // Final iteration: publish the result of this very step.
               if (cnt == LAST_CNT) begin
                  state       <= S_DONE;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  quotient    <= quo_nxt;
                  remainder   <= rem_nxt[31:0];
                  div_by_zero <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider32.sv
// tb_seq_divider32
//   Scoreboard bench for seq_divider32: the driver pushes expected results
//   when it issues a request, and a monitor pops and compares on each done.
module tb_seq_divider32;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   typedef struct {
      logic [31:0] dvd;
      logic [31:0] dvs;
      logic [31:0] q;
      logic [31:0] r;
      logic        z;
      int          cyc;
   } exp_t;

   exp_t sb[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int run    = 0;

   seq_divider32 dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: counts busy cycles and checks every done against the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         run = 0;
      end else begin
         if (busy) run++;
         if (done) begin
            check("busy_with_done", {31'b0, busy}, 32'd0);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("quotient",    quotient,  e.q);
               check("remainder",   remainder, e.r);
               check("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.z});
               check("done_cycle",  32'(cyc), 32'(e.cyc));
               check("busy_cycles", 32'(run), e.z ? 32'd0 : 32'd32);
               if (!e.z) begin
                  logic [63:0] recon;
                  recon = {32'b0, quotient} * {32'b0, e.dvs} + {32'b0, remainder};
                  check("invariant_sum", recon[31:0] | {31'b0, |recon[63:32]}, e.dvd);
                  check("invariant_rem_lt", {31'b0, remainder < e.dvs}, 32'd1);
               end
            end
            run = 0;
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r,
                        input logic z, input bit push);
      @(negedge clk);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      if (push) begin
         exp_t e;
         e.dvd = a; e.dvs = b; e.q = q; e.r = r; e.z = z;
         e.cyc = cyc + 1 + (z ? 0 : 32);
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 200 && sb.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: %0d results still pending, expected 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(negedge clk);
      check("rst_busy",  {31'b0, busy}, 32'd0);
      check("rst_done",  {31'b0, done}, 32'd0);
      check("rst_quo",   quotient, 32'd0);
      check("rst_rem",   remainder, 32'd0);
      check("rst_dbz",   {31'b0, div_by_zero}, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic and boundary vectors, hand-computed.
      issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);                    wait_done();
      issue(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);       wait_done();
      issue(32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1); wait_done();
      issue(32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 1'b1);                      wait_done();
      issue(32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b1);                       wait_done();
      issue(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b1);               wait_done();
      repeat (3) @(negedge clk);

      // start pulsed at RUN cycle 10 must be ignored.
      issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
      repeat (9) @(negedge clk);
      start = 1'b1; dividend = 32'd50; divisor = 32'd3;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      repeat (5) @(negedge clk);

      // start held during the done cycle is accepted back-to-back.
      issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
      repeat (32) @(negedge clk);
      start = 1'b1; dividend = 32'd50; divisor = 32'd3;
      begin
         exp_t e;
         e.dvd = 32'd50; e.dvs = 32'd3; e.q = 32'd16; e.r = 32'd2; e.z = 1'b0;
         e.cyc = cyc + 1 + 32;
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
      wait_done();
      repeat (3) @(negedge clk);

      // Reset at RUN cycle 20: outputs clear at once, no done follows.
      issue(32'd1000, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0);
      repeat (19) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_busy", {31'b0, busy}, 32'd0);
      check("midrst_done", {31'b0, done}, 32'd0);
      check("midrst_quo",  quotient, 32'd0);
      check("midrst_rem",  remainder, 32'd0);
      check("midrst_dbz",  {31'b0, div_by_zero}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check("post_rst_idle", {31'b0, busy}, 32'd0);

      issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
      wait_done();

      // Random pairs checked against / and % plus the invariant.
      for (int k = 0; k < 1000; k++) begin
         logic [31:0] a, b;
         a = $urandom;
         case (k % 4)
            0: begin b = $urandom; if (b == 0) b = 32'd3; end
            1: b = 32'd1;
            2: begin a = $urandom_range(0, 1000); b = $urandom | 32'h8000_0000; end
            default: begin b = $urandom >> $urandom_range(0, 31); if (b == 0) b = 32'd1; end
         endcase
         issue(a, b, a / b, a % b, 1'b0, 1'b1);
         wait_done();
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time exhausted, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
